// File: rtl/nv_ram_rwsthp_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nv_ram_rwsthp_fifo_ctrl_if
// Description : Bundles the producer handshake, the consumer handshake, the
//               nv_ram_rwsthp control/data pins and the status outputs of the
//               RAM-backed FIFO controller.
//               modport slave  - the controller side
//               modport master - the surrounding logic (producer, consumer,
//                                RAM macro)
// Signals     : wr_pvld/wr_prdy/wr_pd       producer handshake
//               rd_pvld/rd_prdy/rd_pd       consumer handshake
//               ram_wa/ram_we/ram_di        RAM write port
//               ram_ra/ram_re/ram_ore       RAM read pipeline controls
//               ram_byp_sel/ram_dbyp        RAM output bypass mux
//               ram_dout                    RAM registered output
//               fifo_cnt/idle               occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
interface nv_ram_rwsthp_fifo_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 4
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;
  logic          ram_byp_sel;
  logic [DW-1:0] ram_dbyp;
  logic [DW-1:0] ram_dout;
  logic [AW:0]   fifo_cnt;
  logic          idle;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd,
    output ram_wa, ram_we, ram_di, ram_ra, ram_re, ram_ore, ram_byp_sel, ram_dbyp,
    output fifo_cnt, idle
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd,
    input  ram_wa, ram_we, ram_di, ram_ra, ram_re, ram_ore, ram_byp_sel, ram_dbyp,
    input  fifo_cnt, idle
  );
endinterface
`default_nettype wire

// File: rtl/nv_ram_rwsthp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nv_ram_rwsthp_fifo_ctrl
// Description : Sequencer that turns one nv_ram_rwsthp RAM (registered read
//               address, registered output, output bypass mux) into a
//               valid/ready FIFO of capacity DEPTH+1. Stage s1 is the
//               captured read address inside the RAM, stage s2 is the RAM
//               output register, which is presented directly as rd_pd.
// Ports       : nvdla_core_clk   clock
//               nvdla_core_rstn  asynchronous active-low reset
//               bus              nv_ram_rwsthp_fifo_ctrl_if.slave (producer,
//                                consumer, RAM pins, fifo_cnt, idle)
// Parameters  : DEPTH (2..32, any value), AW = ceil(log2(DEPTH)), DW
// Options     : NV_FIFO_CTRL_BYPASS_EN - when defined, a write into an empty
//               pipeline is routed through the RAM bypass mux straight into
//               the output register (latency 1 instead of 2).
// Revision    : 1.0 - initial release
// ============================================================================
module nv_ram_rwsthp_fifo_ctrl #(
  parameter int DEPTH = 20,
  parameter int AW    = 5,
  parameter int DW    = 4
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rstn,
  nv_ram_rwsthp_fifo_ctrl_if.slave  bus
);

  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_LAST    = AW'(DEPTH - 1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW:0]   ram_cnt_q,  ram_cnt_d;
  logic [AW:0]   pend_cnt_q, pend_cnt_d;
  logic          s1_vld_q,   s1_vld_d;
  logic          s2_vld_q,   s2_vld_d;

  logic wr_fire;
  logic rd_fire;
  logic wr_acc;
  logic stall;
  logic adv1;
  logic issue;
  logic byp;

  // wr_prdy comes from registered state only.
  assign bus.wr_prdy = (ram_cnt_q < C_DEPTH);
  assign bus.rd_pvld = s2_vld_q;

  assign wr_fire = bus.wr_pvld & bus.wr_prdy;
  assign rd_fire = s2_vld_q & bus.rd_prdy;
  assign stall   = s2_vld_q & ~bus.rd_prdy;
  assign adv1    = s1_vld_q & (~s2_vld_q | rd_fire);

`ifdef NV_FIFO_CTRL_BYPASS_EN
  // Pipeline completely empty (or emptying this cycle): skip the RAM array.
  assign byp = wr_fire & (pend_cnt_q == '0) & ~s1_vld_q & (~s2_vld_q | rd_fire);
`else
  assign byp = 1'b0;
`endif

  // A bypassed write never touches the array or the pointers.
  assign wr_acc = wr_fire & ~byp;

  // Issue is also held off while the output is stalled so that ram_re stays
  // low for the whole stall, even when s1 happens to be empty.
  assign issue = ~byp & ~stall & ((pend_cnt_q != '0) | wr_fire) & (~s1_vld_q | adv1);

  // RAM pins
  assign bus.ram_we      = wr_acc;
  assign bus.ram_wa      = wr_ptr_q;
  assign bus.ram_di      = bus.wr_pd;
  assign bus.ram_re      = issue;
  assign bus.ram_ra      = rd_ptr_q;
  assign bus.ram_ore     = adv1 | byp;
  assign bus.ram_byp_sel = byp;
  assign bus.ram_dbyp    = bus.wr_pd;
  assign bus.rd_pd       = bus.ram_dout;

  assign bus.fifo_cnt = ram_cnt_q + {{AW{1'b0}}, s2_vld_q};
  assign bus.idle     = (bus.fifo_cnt == '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    pend_cnt_d = pend_cnt_q;
    s1_vld_d   = s1_vld_q;
    s2_vld_d   = s2_vld_q;

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + C_PTR_ONE;
    end
    if (issue) begin
      rd_ptr_d = (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + C_PTR_ONE;
    end

    // Entries written but not yet captured as a read address.
    if (wr_acc && !issue) begin
      pend_cnt_d = pend_cnt_q + C_CNT_ONE;
    end else if (!wr_acc && issue) begin
      pend_cnt_d = pend_cnt_q - C_CNT_ONE;
    end

    // A RAM slot is released only when its data moves into s2.
    if (wr_acc && !adv1) begin
      ram_cnt_d = ram_cnt_q + C_CNT_ONE;
    end else if (!wr_acc && adv1) begin
      ram_cnt_d = ram_cnt_q - C_CNT_ONE;
    end

    if (issue) begin
      s1_vld_d = 1'b1;
    end else if (adv1) begin
      s1_vld_d = 1'b0;
    end

    if (bus.ram_ore) begin
      s2_vld_d = 1'b1;
    end else if (rd_fire) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      pend_cnt_q <= '0;
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      pend_cnt_q <= pend_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rwsthp_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nv_ram_rwsthp_fifo_ctrl
// Description : Self-checking bench for nv_ram_rwsthp_fifo_ctrl. Includes a
//               behavioural nv_ram_rwsthp model, a scoreboard queue fed on
//               every accepted write and a monitor that pops and compares on
//               every accepted read, plus occupancy and stall-rule checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nv_ram_rwsthp_fifo_ctrl;

  localparam int DEPTH = 20;
  localparam int AW    = 5;
  localparam int DW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  nv_ram_rwsthp_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  nv_ram_rwsthp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .bus             (bus)
  );

  // Behavioural RAM: write, read-address capture, output register with bypass.
  logic [DW-1:0] mem [32];
  logic [AW-1:0] ra_r;
  always @(posedge clk) begin
    if (bus.ram_we)  mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re)  ra_r <= bus.ram_ra;
    if (bus.ram_ore) bus.ram_dout <= bus.ram_byp_sel ? bus.ram_dbyp : mem[ra_r];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [DW-1:0] exp_q [$];
  int            model_cnt = 0;
  int            rd_fires  = 0;
  logic          prev_stall = 1'b0;
  logic          prev_adv_full = 1'b0;
  logic [DW-1:0] prev_pd = '0;
  logic          wf, rf;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt     = 0;
      prev_stall    = 1'b0;
      prev_adv_full = 1'b0;
    end else begin
      wf = bus.wr_pvld & bus.wr_prdy;
      rf = bus.rd_pvld & bus.rd_prdy;
      chk("fifo_cnt", 32'(bus.fifo_cnt), 32'(model_cnt));
      chk("idle", 32'(bus.idle), 32'(model_cnt == 0));
      if (model_cnt < DEPTH)      chk("wr_prdy_free", 32'(bus.wr_prdy), 1);
      if (model_cnt == DEPTH + 1) chk("wr_prdy_full", 32'(bus.wr_prdy), 0);
      if (prev_adv_full)          chk("wr_prdy_rise", 32'(bus.wr_prdy), 1);
      if (prev_stall) begin
        chk("stall_vld", 32'(bus.rd_pvld), 1);
        chk("stall_pd", 32'(bus.rd_pd), 32'(prev_pd));
      end
      if (bus.rd_pvld & ~bus.rd_prdy) begin
        chk("stall_re", 32'(bus.ram_re), 0);
        chk("stall_ore", 32'(bus.ram_ore), 0);
      end
`ifndef NV_FIFO_CTRL_BYPASS_EN
      chk("byp_sel", 32'(bus.ram_byp_sel), 0);
`endif
      if (rf) begin
        rd_fires++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %0h expected no read at %0t", bus.rd_pd, $time);
        end else begin
          chk("rd_data", 32'(bus.rd_pd), 32'(exp_q.pop_front()));
        end
      end
      if (wf) exp_q.push_back(bus.wr_pd);
      model_cnt     = model_cnt + int'(wf) - int'(rf);
      prev_stall    = bus.rd_pvld & ~bus.rd_prdy;
      prev_pd       = bus.rd_pd;
      prev_adv_full = ~bus.wr_prdy & bus.ram_ore & ~bus.ram_byp_sel;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic fill(input int cnt, input int base);
    int n = 0;
    int g = 0;
    bus.rd_prdy = 1'b0;
    while (n < cnt && g < 200) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = DW'(base + n);
      @(negedge clk);
      if (bus.wr_prdy) n++;
      @(posedge clk); #1;
      g++;
    end
    bus.wr_pvld = 1'b0;
    chk("fill_accepted", 32'(n), 32'(cnt));
  endtask

  task automatic drain(input string nm);
    int g = 0;
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    while (!bus.idle && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk(nm, 32'(bus.idle), 1);
    chk({nm, "_q_empty"}, 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    bus.rd_prdy = 1'b0;
  endtask

  initial begin
    int acc;
    int g;
    int k;
    int rf0;
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = '0;
    bus.rd_prdy = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rd_pvld", 32'(bus.rd_pvld), 0);
    chk("rst_fifo_cnt", 32'(bus.fifo_cnt), 0);
    chk("rst_idle", 32'(bus.idle), 1);
    chk("rst_wr_prdy", 32'(bus.wr_prdy), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write latency
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'hA;
    @(posedge clk); #1;
    bus.wr_pvld = 1'b0;
    @(negedge clk);
`ifdef NV_FIFO_CTRL_BYPASS_EN
    chk("lat_c1_vld", 32'(bus.rd_pvld), 1);
`else
    chk("lat_c1_vld", 32'(bus.rd_pvld), 0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_c2_vld", 32'(bus.rd_pvld), 1);
    chk("lat_c2_pd", 32'(bus.rd_pd), 32'hA);
    @(posedge clk); #1;
    bus.rd_prdy = 1'b1;
    @(posedge clk); #1;
    bus.rd_prdy = 1'b0;
    @(negedge clk);
    chk("idle_after_read", 32'(bus.idle), 1);
    @(posedge clk); #1;

    // Fill to capacity with the consumer stalled, then try one more
    fill(DEPTH + 1, 0);
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("full_cnt", 32'(bus.fifo_cnt), 32'(DEPTH + 1));
      chk("full_prdy", 32'(bus.wr_prdy), 0);
      @(posedge clk); #1;
    end
    drain("fill_drain");

    // Streaming across pointer wrap
    bus.rd_prdy = 1'b1;
    rf0 = rd_fires;
    for (int i = 0; i < 50; i++) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = DW'($urandom);
      @(negedge clk);
      chk("wrap_cnt_le3", 32'(bus.fifo_cnt <= 3), 1);
      @(posedge clk); #1;
    end
    chk("wrap_rate", 32'((rd_fires - rf0) >= 48), 1);
    drain("wrap_drain");

    // Random traffic with consumer backpressure
    acc = 0;
    g   = 0;
    while (acc < 500 && g < 5000) begin
      bus.wr_pvld = ($urandom_range(0, 9) < 7);
      bus.wr_pd   = DW'($urandom);
      bus.rd_prdy = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (bus.wr_pvld & bus.wr_prdy) acc++;
      @(posedge clk); #1;
      g++;
    end
    chk("rand_accepted", 32'(acc), 500);
    drain("rand_drain");

    // Full with simultaneous pop and push
    fill(DEPTH + 1, 7);
    @(negedge clk);
    chk("fullpp_start_cnt", 32'(bus.fifo_cnt), 32'(DEPTH + 1));
    @(posedge clk); #1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h9;
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    chk("fullpp_refused", 32'(bus.wr_prdy), 0);
    @(posedge clk); #1;
    bus.rd_prdy = 1'b0;
    k = 1;
    @(negedge clk);
    while (!bus.wr_prdy && k < 5) begin
      @(posedge clk); #1;
      @(negedge clk);
      k++;
    end
`ifndef NV_FIFO_CTRL_BYPASS_EN
    chk("fullpp_accept_next", 32'(k), 1);
`endif
    chk("fullpp_accepted", 32'(bus.wr_prdy), 1);
    @(posedge clk); #1;
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    chk("fullpp_cnt", 32'(bus.fifo_cnt), 32'(DEPTH + 1));
    @(posedge clk); #1;
    drain("fullpp_drain");

    // Reset in the middle of traffic
    fill(7, 3);
    @(negedge clk);
    chk("pre_rst_cnt", 32'(bus.fifo_cnt), 7);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_pvld", 32'(bus.rd_pvld), 0);
    chk("mid_rst_cnt", 32'(bus.fifo_cnt), 0);
    chk("mid_rst_idle", 32'(bus.idle), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 4'h5;
    @(posedge clk); #1;
    bus.wr_pvld = 1'b0;
    g = 0;
    @(negedge clk);
    while (!bus.rd_pvld && g < 10) begin
      @(negedge clk);
      g++;
    end
    chk("post_rst_vld", 32'(bus.rd_pvld), 1);
    chk("post_rst_pd", 32'(bus.rd_pd), 32'h5);
    @(posedge clk); #1;
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
